pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL provide parameter WIDTH, 32, PC and target width in bits (16..64).
REQ-002 SHALL provide parameter RESET_VECTOR, 32'h0000_0000, value loaded into pc_out on reset.
REQ-003 SHALL provide parameter EXC_VECTOR, 32'h0000_0080, exception redirect address.
REQ-004 SHALL provide parameter INC, 4, sequential increment in bytes; a power of two, at least 1.
REQ-005 SHALL provide parameter RAS_DEPTH, 4, return-stack entries; a power of two, at least 2; used only with PC_RAS_EN.
REQ-006 SHALL provide port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL provide port stall, input, 1, hold pc_out.
REQ-009 SHALL provide port branch_taken, input, 1, redirect to branch_target.
REQ-010 SHALL provide port branch_target, input, WIDTH, branch destination.
REQ-011 SHALL provide port jump, input, 1, redirect to jump_target.
REQ-012 SHALL provide port jump_target, input, WIDTH, jump destination.
REQ-013 SHALL provide port exc_req, input, 1, redirect to EXC_VECTOR.
REQ-014 SHALL provide port call, input, 1, qualifies jump as a call; ignored without PC_RAS_EN.
REQ-015 SHALL provide port ret, input, 1, qualifies jump as a return; ignored without PC_RAS_EN.
REQ-016 SHALL provide port pc_out, output, WIDTH, current fetch address.
REQ-017 SHALL provide port pc_next_seq, output, WIDTH, combinational pc_out+INC.
REQ-018 SHALL provide port pending, output, 1, high while a redirect is held in state HOLD_PEND.
REQ-019 SHALL provide port misalign, output, 1, one-cycle pulse on loading a misaligned target.

Function
REQ-020 SHALL implement the states RUN, HOLD and HOLD_PEND; pending SHALL equal (state==HOLD_PEND).
REQ-021 SHALL, in RUN with stall=0, load pc_out on each edge using priority exc_req > branch_taken > jump > pc_out+INC.
REQ-022 SHALL compute pc_out+INC modulo 2^WIDTH; a wrap past the top address SHALL NOT be flagged.
REQ-023 SHALL, when stall=1 and a branch or jump is present with no exc_req, hold pc_out, capture the target into the pending register (branch over jump) and enter HOLD_PEND.
REQ-024 SHALL, when stall=1 with no request, hold pc_out and enter or stay in HOLD.
REQ-025 SHALL, in HOLD_PEND, ignore further branch and jump requests while stall=1.
REQ-026 SHALL, on the first edge with stall=0 in HOLD_PEND, load the pending target, discard any same-cycle branch or jump, and return to RUN.
REQ-027 SHALL, on exc_req=1 in any state, regardless of stall, load EXC_VECTOR, clear the pending register and go to RUN.
REQ-028 SHALL, for any loaded target whose bits [log2(INC)-1:0] are nonzero, force those bits to 0 and assert misalign for exactly that one cycle.
REQ-029 SHALL, when INC=1, skip the alignment forcing of REQ-028 and hold misalign at 0.
REQ-030 SHALL give every redirect a latency of one edge from request to pc_out, or one edge after stall falls for a held redirect.

Reset
REQ-031 SHALL, while reset_n=0 and regardless of clk, force pc_out=RESET_VECTOR, state=RUN, pending=0, misalign=0 and the return stack empty.
REQ-032 SHALL, on reset asserted mid-stall or mid-pending, discard the held target.
REQ-033 SHALL, on the first rising edge after reset_n rises, perform normal RUN behaviour.

Configuration
REQ-034 SHALL, when macro PC_RAS_EN is defined, include a RAS_DEPTH circular return stack.
REQ-035 SHALL, with PC_RAS_EN defined, push pc_out+INC on jump&call, overwriting the oldest entry when full.
REQ-036 SHALL, with PC_RAS_EN defined, use the popped top entry instead of jump_target on jump&ret; an empty stack SHALL use jump_target and SHALL NOT pop.
REQ-037 SHALL, with PC_RAS_EN defined, apply push and pop only when the request is accepted (RUN) or captured (into HOLD_PEND).
REQ-038 SHALL, without PC_RAS_EN, contain no stack storage and treat call and ret as don't-care.

Verification
REQ-039 SHALL cover: reset_n=0 then release, stall=0, no requests, WIDTH=32 -> pc_out 0, 4, 8, 12 on successive edges.
REQ-040 SHALL cover: pc_out=32'hFFFF_FFFC, stall=0 -> next pc_out=0, misalign=0.
REQ-041 SHALL cover: stall=1 with branch_taken and branch_target=32'h100 for one cycle, stall held 3 cycles -> pc_out frozen, pending=1; stall=0 -> pc_out=32'h100, pending=0.
REQ-042 SHALL cover: stall=1 with pending set, then exc_req=1 -> next pc_out=32'h80, pending=0.
REQ-043 SHALL cover: jump with jump_target=32'h203 -> pc_out=32'h200, misalign high for exactly one cycle.
REQ-044 SHALL cover, with PC_RAS_EN: call at pc_out=32'h40 to 32'h300, then ret -> pc_out=32'h44; a second ret on the empty stack -> pc_out=jump_target.

Source files
------------

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pc_sequencer_if : request/response bundle between fetch control and the    |
// |                   program-counter sequencer                                |
// | Revision        : 1.0                                                      |
// +---------------------------------------------------------------------------+

interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             exc_req;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] pc_next_seq;
  logic             pending;
  logic             misalign;

  modport master (
    output stall,
    output branch_taken,
    output branch_target,
    output jump,
    output jump_target,
    output exc_req,
    output call,
    output ret,
    input  pc_out,
    input  pc_next_seq,
    input  pending,
    input  misalign
  );

  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  jump,
    input  jump_target,
    input  exc_req,
    input  call,
    input  ret,
    output pc_out,
    output pc_next_seq,
    output pending,
    output misalign
  );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pc_sequencer : fetch PC sequencer with stall-held redirects, exception     |
// |                vector and target alignment; optional return stack under    |
// |                macro PC_RAS_EN                                             |
// | Revision     : 1.0                                                         |
// +---------------------------------------------------------------------------+

module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int               INC          = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  pc_sequencer_if.slave    bus
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_HOLD      = 2'd1;
  localparam logic [1:0] ST_HOLD_PEND = 2'd2;

  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pend_tgt;
  logic [WIDTH-1:0] pend_tgt_nxt;
  logic             misalign_r;
  logic             misalign_nxt;
  logic             load_en;
  logic [WIDTH-1:0] load_tgt;
  logic [WIDTH-1:0] jump_dest;
  logic             jump_take;

  assign pc_seq = pc + INC_W;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_tgt_nxt = pend_tgt;
    load_en      = 1'b0;
    load_tgt     = '0;
    jump_take    = 1'b0;

    if (bus.exc_req) begin
      load_en      = 1'b1;
      load_tgt     = EXC_VECTOR;
      pend_tgt_nxt = '0;
      state_nxt    = ST_RUN;
    end else if (bus.stall) begin
      if (state != ST_HOLD_PEND) begin
        if (bus.branch_taken) begin
          pend_tgt_nxt = bus.branch_target;
          state_nxt    = ST_HOLD_PEND;
        end else if (bus.jump) begin
          pend_tgt_nxt = jump_dest;
          jump_take    = 1'b1;
          state_nxt    = ST_HOLD_PEND;
        end else begin
          state_nxt    = ST_HOLD;
        end
      end
    end else begin
      state_nxt = ST_RUN;
      // A held redirect wins over anything presented on the release cycle.
      if (state == ST_HOLD_PEND) begin
        load_en      = 1'b1;
        load_tgt     = pend_tgt;
        pend_tgt_nxt = '0;
      end else if (bus.branch_taken) begin
        load_en  = 1'b1;
        load_tgt = bus.branch_target;
      end else if (bus.jump) begin
        load_en   = 1'b1;
        load_tgt  = jump_dest;
        jump_take = 1'b1;
      end else begin
        pc_nxt = pc_seq;
      end
    end

    if (load_en) begin
      pc_nxt = load_tgt & ~ALIGN_MASK;
    end
  end

  // ALIGN_MASK is zero for INC=1, so no forcing and no flag in that build.
  assign misalign_nxt = load_en & (|(load_tgt & ALIGN_MASK));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      pc         <= RESET_VECTOR;
      pend_tgt   <= '0;
      misalign_r <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_tgt   <= pend_tgt_nxt;
      misalign_r <= misalign_nxt;
    end
  end

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W:0]   ras_cnt;
  logic [PTR_W-1:0] ras_top_idx;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_push;
  logic             ras_pop;
  logic             ret_hit;

  assign ras_top_idx = ras_ptr - PTR_W'(1);
  assign ras_empty   = (ras_cnt == '0);
  assign ras_full    = (ras_cnt == (PTR_W+1)'(RAS_DEPTH));

  // Call takes precedence over ret when both qualify the same jump.
  assign ret_hit   = bus.ret & ~bus.call & ~ras_empty;
  assign jump_dest = ret_hit ? ras_mem[ras_top_idx] : bus.jump_target;
  assign ras_push  = jump_take & bus.call;
  assign ras_pop   = jump_take & ret_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (!ras_full) begin
        ras_cnt <= ras_cnt + (PTR_W+1)'(1);
      end
    end else if (ras_pop) begin
      ras_ptr <= ras_top_idx;
      ras_cnt <= ras_cnt - (PTR_W+1)'(1);
    end
  end

  // Pushing onto a full stack reuses the oldest slot via pointer wrap.
  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_ptr] <= pc_seq;
    end
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;

  logic unused_ras;

  assign jump_dest  = bus.jump_target;
  assign unused_ras = &{1'b0, bus.call, bus.ret, jump_take};
`endif

  assign bus.pc_out      = pc;
  assign bus.pc_next_seq = pc_seq;
  assign bus.pending     = (state == ST_HOLD_PEND);
  assign bus.misalign    = misalign_r;

endmodule

`default_nettype wire
